// File: rtl/shifter_stream_pkg.sv
// Shared definitions for the shifter family: FSM encoding and compile-time sizing helpers.
package shifter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  function automatic int unsigned num_chunks(input int unsigned in_width,
                                             input int unsigned out_width,
                                             input int unsigned pad);
    return in_width / out_width + (((pad != 0) && (in_width % out_width != 0)) ? 1 : 0);
  endfunction

endpackage

// File: rtl/shifter_stream_if.sv
// Producer/consumer bundle for shifter_stream: input handshake, vector, chunk output and status.
interface shifter_stream_if #(
  parameter int unsigned IN_WIDTH  = 128,
  parameter int unsigned OUT_WIDTH = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  long_vector_in;
  logic                 fifo_full;
  logic [OUT_WIDTH-1:0] short_vector_out;
  logic                 short_vector_out_valid;
  logic                 short_vector_out_last;
  logic                 done;
  logic                 busy;

  modport master (
    output in_valid, long_vector_in, fifo_full,
    input  in_ready, short_vector_out, short_vector_out_valid,
           short_vector_out_last, done, busy
  );

  modport slave (
    input  in_valid, long_vector_in, fifo_full,
    output in_ready, short_vector_out, short_vector_out_valid,
           short_vector_out_last, done, busy
  );
endinterface

// File: rtl/shifter_stream_slice.sv
// Shift register that presents the next chunk; zero fill makes the pad chunk fall out naturally.
module shifter_stream_slice #(
  parameter int unsigned IN_WIDTH  = 128,
  parameter int unsigned OUT_WIDTH = 7,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [IN_WIDTH-1:0]  load_data,
  input  logic                 advance,
  output logic [OUT_WIDTH-1:0] chunk
);

  logic [IN_WIDTH-1:0] shift_reg;

  // load wins over advance: on a back-to-back reload the old vector is finished
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= load_data;
    end else if (advance) begin
      shift_reg <= MSB_FIRST ? (shift_reg << OUT_WIDTH) : (shift_reg >> OUT_WIDTH);
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign chunk = shift_reg[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb
      assign chunk = shift_reg[OUT_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/shifter_stream.sv
// Streams IN_WIDTH-bit vectors out as OUT_WIDTH-bit chunks with a one-deep pending buffer.
module shifter_stream
  import shifter_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 128,
  parameter int unsigned OUT_WIDTH     = 7,
  parameter bit          MSB_FIRST     = 1'b1,
  parameter bit          PAD_REMAINDER = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  shifter_stream_if.slave bus
);

  localparam int unsigned NCH = num_chunks(IN_WIDTH, OUT_WIDTH, PAD_REMAINDER);
  localparam int unsigned CW  = clog2(NCH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  state_t                 state;
  logic [CW-1:0]          count;
  logic                   pend_valid;
  logic [IN_WIDTH-1:0]    pend_buf;
  logic [OUT_WIDTH-1:0]   chunk;
  logic                   accept;
  logic                   issue;
  logic                   final_chunk;
  logic                   load;
  logic [IN_WIDTH-1:0]    load_data;

  assign bus.in_ready = !pend_valid;
  assign bus.busy     = (state == SHIFT) || pend_valid;

  assign accept      = bus.in_valid && !pend_valid;
  assign issue       = (state == SHIFT) && !bus.fifo_full;
  assign final_chunk = issue && (count == LAST_IDX);
  assign load        = ((state == IDLE) && accept) || (final_chunk && (pend_valid || accept));
  assign load_data   = pend_valid ? pend_buf : bus.long_vector_in;

  shifter_stream_slice #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_slice (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_data(load_data),
    .advance  (issue),
    .chunk    (chunk)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                      <= IDLE;
      count                      <= '0;
      pend_valid                 <= 1'b0;
      pend_buf                   <= '0;
      bus.short_vector_out       <= '0;
      bus.short_vector_out_valid <= 1'b0;
      bus.short_vector_out_last  <= 1'b0;
      bus.done                   <= 1'b0;
    end else begin
      bus.short_vector_out_valid <= issue;
      bus.short_vector_out_last  <= final_chunk;
      bus.done                   <= final_chunk;
      if (issue) bus.short_vector_out <= chunk;

      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            count <= '0;
          end
        end
        SHIFT: begin
          if (final_chunk) begin
            count <= '0;
            // pending vector first; otherwise a same-edge accept is loaded directly
            if (pend_valid)   pend_valid <= 1'b0;
            else if (!accept) state      <= IDLE;
          end else begin
            if (issue) count <= count + CW'(1);
            if (accept) begin
              pend_buf   <= bus.long_vector_in;
              pend_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_stream.sv
// Directed bench for shifter_stream: default, padded and LSB-first instances driven in one linear sequence.
module tb_shifter_stream;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  localparam logic [127:0] VA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] VB = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF1;
  localparam logic [127:0] VC = 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9999_6666;
  localparam logic [127:0] VP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3213;

  shifter_stream_if #(.IN_WIDTH(128), .OUT_WIDTH(7)) b_def ();
  shifter_stream_if #(.IN_WIDTH(128), .OUT_WIDTH(7)) b_pad ();
  shifter_stream_if #(.IN_WIDTH(14),  .OUT_WIDTH(7)) b_lsb ();

  shifter_stream #(.IN_WIDTH(128), .OUT_WIDTH(7), .MSB_FIRST(1'b1), .PAD_REMAINDER(1'b0))
    u_def (.clock(clock), .reset(reset), .bus(b_def));
  shifter_stream #(.IN_WIDTH(128), .OUT_WIDTH(7), .MSB_FIRST(1'b1), .PAD_REMAINDER(1'b1))
    u_pad (.clock(clock), .reset(reset), .bus(b_pad));
  shifter_stream #(.IN_WIDTH(14), .OUT_WIDTH(7), .MSB_FIRST(1'b0), .PAD_REMAINDER(1'b0))
    u_lsb (.clock(clock), .reset(reset), .bus(b_lsb));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // chunk k of an MSB-first 7-bit slicing, zero beyond bit 0
  function automatic logic [6:0] exp_msb(input logic [127:0] v, input int k);
    logic [6:0] r;
    int idx;
    r = '0;
    for (int b = 0; b < 7; b++) begin
      idx = 127 - 7 * k - b;
      if (idx >= 0) r[6-b] = v[idx];
    end
    return r;
  endfunction

  task automatic run_def(input logic [127:0] v, input int k0, input int k1, input string tag);
    for (int k = k0; k <= k1; k++) begin
      step();
      check($sformatf("%s_valid%0d", tag, k), b_def.short_vector_out_valid, 1'b1);
      check($sformatf("%s_data%0d", tag, k), b_def.short_vector_out, exp_msb(v, k));
      check($sformatf("%s_last%0d", tag, k), b_def.short_vector_out_last, k == 17);
      check($sformatf("%s_done%0d", tag, k), b_def.done, k == 17);
    end
  endtask

  task automatic check_def_idle(input string tag);
    check({tag, "_valid"}, b_def.short_vector_out_valid, 1'b0);
    check({tag, "_done"}, b_def.done, 1'b0);
    check({tag, "_busy"}, b_def.busy, 1'b0);
    check({tag, "_ready"}, b_def.in_ready, 1'b1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    b_def.in_valid = 1'b0; b_def.long_vector_in = '0; b_def.fifo_full = 1'b0;
    b_pad.in_valid = 1'b0; b_pad.long_vector_in = '0; b_pad.fifo_full = 1'b0;
    b_lsb.in_valid = 1'b0; b_lsb.long_vector_in = '0; b_lsb.fifo_full = 1'b0;
    repeat (3) step();

    check("rst_ready", b_def.in_ready, 1'b1);
    check("rst_valid", b_def.short_vector_out_valid, 1'b0);
    check("rst_last", b_def.short_vector_out_last, 1'b0);
    check("rst_done", b_def.done, 1'b0);
    check("rst_busy", b_def.busy, 1'b0);
    check("rst_out", b_def.short_vector_out, 7'h00);
    check("rst_pad_ready", b_pad.in_ready, 1'b1);
    check("rst_lsb_out", b_lsb.short_vector_out, 7'h00);
    reset = 1'b1;
    step();

    // T1: single vector, first chunk one cycle after accept
    b_def.in_valid = 1'b1; b_def.long_vector_in = VA;
    step();
    b_def.in_valid = 1'b0;
    check("t1_acc_valid", b_def.short_vector_out_valid, 1'b0);
    check("t1_acc_busy", b_def.busy, 1'b1);
    check("t1_acc_ready", b_def.in_ready, 1'b1);
    run_def(VA, 0, 17, "t1");
    step();
    check_def_idle("t1_end");

    // T2: padded remainder chunk
    b_pad.in_valid = 1'b1; b_pad.long_vector_in = VP;
    step();
    b_pad.in_valid = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      step();
      check($sformatf("t2_valid%0d", k), b_pad.short_vector_out_valid, 1'b1);
      check($sformatf("t2_data%0d", k), b_pad.short_vector_out, exp_msb(VP, k));
      check($sformatf("t2_last%0d", k), b_pad.short_vector_out_last, k == 18);
      check($sformatf("t2_done%0d", k), b_pad.done, k == 18);
    end
    check("t2_padchunk", b_pad.short_vector_out, 7'h60);
    step();
    check("t2_end_valid", b_pad.short_vector_out_valid, 1'b0);
    check("t2_end_busy", b_pad.busy, 1'b0);

    // T3: LSB-first 14/7
    b_lsb.in_valid = 1'b1; b_lsb.long_vector_in = 14'h2A55;
    step();
    b_lsb.in_valid = 1'b0;
    step();
    check("t3_c0_valid", b_lsb.short_vector_out_valid, 1'b1);
    check("t3_c0_data", b_lsb.short_vector_out, 7'h55);
    check("t3_c0_done", b_lsb.done, 1'b0);
    step();
    check("t3_c1_valid", b_lsb.short_vector_out_valid, 1'b1);
    check("t3_c1_data", b_lsb.short_vector_out, 7'h54);
    check("t3_c1_last", b_lsb.short_vector_out_last, 1'b1);
    check("t3_c1_done", b_lsb.done, 1'b1);
    step();
    check("t3_end_valid", b_lsb.short_vector_out_valid, 1'b0);
    check("t3_end_busy", b_lsb.busy, 1'b0);

    // T4: ten-cycle stall after chunk 6
    b_def.in_valid = 1'b1; b_def.long_vector_in = VB;
    step();
    b_def.in_valid = 1'b0;
    run_def(VB, 0, 5, "t4a");
    b_def.fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t4_stall_valid%0d", i), b_def.short_vector_out_valid, 1'b0);
      check($sformatf("t4_stall_hold%0d", i), b_def.short_vector_out, exp_msb(VB, 5));
      check($sformatf("t4_stall_busy%0d", i), b_def.busy, 1'b1);
    end
    b_def.fifo_full = 1'b0;
    run_def(VB, 6, 17, "t4b");
    step();
    check_def_idle("t4_end");

    // T5: B queued behind A, no gap between them
    b_def.in_valid = 1'b1; b_def.long_vector_in = VA;
    step();
    b_def.long_vector_in = VB;
    step();
    b_def.in_valid = 1'b0;
    check("t5_a0_valid", b_def.short_vector_out_valid, 1'b1);
    check("t5_a0_data", b_def.short_vector_out, exp_msb(VA, 0));
    check("t5_pend_ready", b_def.in_ready, 1'b0);
    run_def(VA, 1, 17, "t5a");
    check("t5_mid_ready", b_def.in_ready, 1'b1);
    check("t5_mid_busy", b_def.busy, 1'b1);
    run_def(VB, 0, 17, "t5b");
    step();
    check_def_idle("t5_end");

    // T7: accept on the final-chunk edge loads straight into the shifter
    b_def.in_valid = 1'b1; b_def.long_vector_in = VA;
    step();
    b_def.in_valid = 1'b0;
    run_def(VA, 0, 16, "t7a");
    b_def.in_valid = 1'b1; b_def.long_vector_in = VC;
    step();
    b_def.in_valid = 1'b0;
    check("t7_a17_data", b_def.short_vector_out, exp_msb(VA, 17));
    check("t7_a17_done", b_def.done, 1'b1);
    check("t7_a17_ready", b_def.in_ready, 1'b1);
    run_def(VC, 0, 17, "t7c");
    step();
    check_def_idle("t7_end");

    // T6: reset mid-vector with a pending vector
    b_def.in_valid = 1'b1; b_def.long_vector_in = VA;
    step();
    b_def.long_vector_in = VB;
    step();
    b_def.in_valid = 1'b0;
    run_def(VA, 1, 4, "t6a");
    reset = 1'b0;
    #1;
    check("t6_rst_out", b_def.short_vector_out, 7'h00);
    check("t6_rst_last", b_def.short_vector_out_last, 1'b0);
    check_def_idle("t6_rst");
    step();
    step();
    check_def_idle("t6_hold");
    reset = 1'b1;
    step();
    check_def_idle("t6_rel");
    b_def.in_valid = 1'b1; b_def.long_vector_in = VC;
    step();
    b_def.in_valid = 1'b0;
    run_def(VC, 0, 17, "t6c");
    step();
    check_def_idle("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
